// File: rtl/circular_pointer_mc_fifo.sv
// Multi-channel FIFO: CHANNELS independent circular buffers sharing one
// push port and one pop port, registered read data, sticky error flags.
//
// Ports:
//   clk, rst (async, active-low)
//   push/push_ch/data_in : write request, target channel, write data
//   pop/pop_ch           : read request and source channel
//   err_clr              : clears overflow/underflow
//   data_out/_vld        : word popped in the previous cycle
//   empty/full/almost_full/count : per-channel status from registered counts
//   overflow/underflow   : sticky rejected-push / rejected-pop flags
module circular_pointer_mc_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  parameter int AFULL_TH = DEPTH - 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [CW-1:0]          push_ch,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   pop,
  input  logic [CW-1:0]          pop_ch,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_out_vld,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS-1:0]    full,
  output logic [CHANNELS-1:0]    almost_full,
  output logic [CHANNELS*NW-1:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  logic [WIDTH-1:0] mem_q [CHANNELS][DEPTH];
  logic [PW-1:0]    wp_q  [CHANNELS];
  logic [PW-1:0]    wp_d  [CHANNELS];
  logic [PW-1:0]    rp_q  [CHANNELS];
  logic [PW-1:0]    rp_d  [CHANNELS];
  logic [NW-1:0]    cnt_q [CHANNELS];
  logic [NW-1:0]    cnt_d [CHANNELS];

  logic [CHANNELS-1:0] push_acc;
  logic [CHANNELS-1:0] pop_acc;
  logic [WIDTH-1:0]    rd_data;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Out-of-range channel numbers match no loop index, so they are
  // rejected without a separate range compare.
  always_comb begin
    push_acc = '0;
    pop_acc  = '0;
    rd_data  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wp_d[c]  = wp_q[c];
      rp_d[c]  = rp_q[c];
      cnt_d[c] = cnt_q[c];
      pop_acc[c] = pop && (pop_ch == CW'(c))
                   && (cnt_q[c] != '0);
      // A full channel still accepts a push when it is popped this cycle.
      push_acc[c] = push && (push_ch == CW'(c))
                    && ((cnt_q[c] != NW'(DEPTH)) || pop_acc[c]);
      if (pop_acc[c]) begin
        rd_data = mem_q[c][rp_q[c]];
        rp_d[c] = ptr_inc(rp_q[c]);
      end
      if (push_acc[c]) begin
        wp_d[c] = ptr_inc(wp_q[c]);
      end
      unique case ({push_acc[c], pop_acc[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  // A new error in the same cycle overrides err_clr.
  always_comb begin
    vld_d  = |pop_acc;
    dout_d = (|pop_acc) ? rd_data : dout_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push && !(|push_acc)) ovf_d = 1'b1;
    if (pop && !(|pop_acc))   udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp_q[c]  <= wp_d[c];
        rp_q[c]  <= rp_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push_acc[c]) mem_q[c][wp_q[c]] <= data_in;
    end
  end

  always_comb begin
    empty       = '0;
    full        = '0;
    almost_full = '0;
    count       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      empty[c]          = (cnt_q[c] == '0);
      full[c]           = (cnt_q[c] == NW'(DEPTH));
      almost_full[c]    = (cnt_q[c] >= NW'(AFULL_TH));
      count[c*NW +: NW] = cnt_q[c];
    end
  end

  assign data_out     = dout_q;
  assign data_out_vld = vld_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_circular_pointer_mc_fifo.sv
// Bench for circular_pointer_mc_fifo: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_circular_pointer_mc_fifo;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CH  = 2;
  localparam int AF  = D - 1;
  localparam int CW  = 1;
  localparam int NW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [CW-1:0] push_ch;
  logic [W-1:0]  data_in;
  logic          pop;
  logic [CW-1:0] pop_ch;
  logic          err_clr;
  logic [W-1:0]  data_out;
  logic          data_out_vld;
  logic [CH-1:0] empty, full, almost_full;
  logic [CH*NW-1:0] count;
  logic          overflow, underflow;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] mq [CH][$];
  logic [W-1:0] m_do;
  bit           m_vld, m_ovf, m_udf;

  always #5 clk = ~clk;

  circular_pointer_mc_fifo #(
    .WIDTH(W), .DEPTH(D), .CHANNELS(CH), .AFULL_TH(AF)
  ) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_ch(push_ch), .data_in(data_in),
    .pop(pop), .pop_ch(pop_ch), .err_clr(err_clr),
    .data_out(data_out), .data_out_vld(data_out_vld),
    .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      int n;
      n = mq[c].size();
      check($sformatf("%s cnt%0d", tag, c),
            32'(count[c*NW +: NW]), 32'(n));
      check($sformatf("%s empty%0d", tag, c),
            32'(empty[c]), 32'(n == 0));
      check($sformatf("%s full%0d", tag, c),
            32'(full[c]), 32'(n == D));
      check($sformatf("%s afull%0d", tag, c),
            32'(almost_full[c]), 32'(n >= AF));
    end
    check({tag, " vld"}, 32'(data_out_vld), 32'(m_vld));
    check({tag, " dout"}, 32'(data_out), 32'(m_do));
    check({tag, " ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, " udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_do  = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input string tag,
                     input bit pu, input int pc, input logic [W-1:0] d,
                     input bit po, input int oc, input bit clr);
    bit pop_ok, push_ok;
    push    = pu;
    push_ch = CW'(pc);
    data_in = d;
    pop     = po;
    pop_ch  = CW'(oc);
    err_clr = clr;
    pop_ok  = po && (oc < CH) && (mq[oc].size() > 0);
    push_ok = pu && (pc < CH)
              && ((mq[pc].size() < D) || (pop_ok && oc == pc));
    @(posedge clk);
    if (pop_ok) begin
      m_do  = mq[oc].pop_front();
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (push_ok) mq[pc].push_back(d);
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (pu && !push_ok) m_ovf = 1'b1;
    if (po && !pop_ok)  m_udf = 1'b1;
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    push = 0; push_ch = '0; data_in = '0;
    pop = 0; pop_ch = '0; err_clr = 0;
    model_reset();
    #2;
    check_all("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Ordered push/pop on ch0.
    cyc("p11", 1, 0, 8'h11, 0, 0, 0);
    cyc("p22", 1, 0, 8'h22, 0, 0, 0);
    cyc("p33", 1, 0, 8'h33, 0, 0, 0);
    cyc("r1",  0, 0, '0, 1, 0, 0);
    check("r1 data", 32'(data_out), 32'h11);
    cyc("r2",  0, 0, '0, 1, 0, 0);
    cyc("r3",  0, 0, '0, 1, 0, 0);
    check("r3 data", 32'(data_out), 32'h33);
    idle("r idle");

    // Fill ch1 and overflow it.
    for (int i = 0; i < 5; i++)
      cyc($sformatf("f1_%0d", i), 1, 1, 8'hA0 + 8'(i), 0, 0, 0);
    check("ovf ch1", 32'(overflow), 32'h1);
    check("ovf cnt1", 32'(count[NW +: NW]), 32'd4);
    cyc("clr", 0, 0, '0, 0, 0, 1);

    // Full ch0 with simultaneous push+pop, wrapping pointers.
    for (int i = 0; i < 4; i++)
      cyc($sformatf("f0_%0d", i), 1, 0, 8'h40 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("pp_%0d", i), 1, 0, 8'h50 + 8'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("d0_%0d", i), 0, 0, '0, 1, 0, 0);

    // Empty ch0: pop rejected, push accepted, no bypass.
    cyc("eb", 1, 0, 8'hAA, 1, 0, 0);
    check("eb udf", 32'(underflow), 32'h1);
    check("eb vld", 32'(data_out_vld), 32'h0);
    cyc("eb pop", 0, 0, '0, 1, 0, 1);
    check("eb data", 32'(data_out), 32'hAA);

    // Cross-channel push/pop.
    for (int i = 0; i < 4; i++) cyc("dr1", 0, 0, '0, 1, 1, 0);
    cyc("c1", 1, 1, 8'h5C, 0, 0, 1);
    cyc("x", 1, 0, 8'h77, 1, 1, 0);
    check("x data", 32'(data_out), 32'h5C);

    // Asynchronous reset mid-stream.
    cyc("a0", 1, 0, 8'h01, 0, 0, 0);
    cyc("a1", 1, 1, 8'h02, 0, 0, 0);
    cyc("a2", 1, 1, 8'h03, 0, 0, 0);
    cyc("a3", 1, 1, 8'h04, 0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    @(negedge clk);
    rst = 1'b1;
    cyc("arst pop", 0, 0, '0, 1, 0, 0);
    cyc("arst clr", 0, 0, '0, 0, 0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rnd rst");
        @(negedge clk);
        rst = 1'b1;
      end else begin
        cyc($sformatf("rnd%0d", i),
            $urandom_range(0, 99) < 60, $urandom_range(0, CH - 1),
            W'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, CH - 1), $urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
